// File: rtl/trng_vn_packer_if.sv
// Output word channel of the TRNG post-processor: valid/ready handshake carrying W-bit words.
// The master drives valid and data; the slave answers with ready.
interface trng_vn_packer_if #(
  parameter int W = 32
);
  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/trng_vn_packer.sv
// Von Neumann debiasing of a raw TRNG bit stream, packed into W-bit words behind a valid/ready
// output, guarded by a sticky repetition-count health test on the raw samples.
module trng_vn_packer #(
  parameter int W          = 32,
  parameter int RCT_CUTOFF = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               raw_bit_i,
  input  logic               en_i,
  output logic               health_fail_o,
  trng_vn_packer_if.master   out_if
);

  localparam int FCW = $clog2(W + 1);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           phase_q, phase_d;
  logic           first_q, first_d;
  logic           lastb_q, lastb_d;
  logic [7:0]     rcnt_q, rcnt_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   data_q, data_d;
  logic           hf_q, hf_d;

  logic           sample;
  logic           emit;
  logic           out_free;
  logic           trip;
  logic [W-1:0]   acc_shift;

  assign sample    = en_i && (state_q != ST_FAIL);
  assign emit      = sample && phase_q && (raw_bit_i != first_q);
  assign out_free  = !valid_q || out_if.ready;
  assign acc_shift = {acc_q[W-2:0], first_q};

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    first_d = first_q;
    lastb_d = lastb_q;
    rcnt_d  = rcnt_q;
    acc_d   = acc_q;
    fcnt_d  = fcnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    hf_d    = hf_q;
    trip    = 1'b0;

    if (valid_q && out_if.ready) begin
      valid_d = 1'b0;
    end

    // rcnt of zero marks "no sample seen since reset"
    if (sample) begin
      phase_d = ~phase_q;
      lastb_d = raw_bit_i;
      if (!phase_q) begin
        first_d = raw_bit_i;
      end
      if (rcnt_q == 8'd0 || raw_bit_i != lastb_q) begin
        rcnt_d = 8'd1;
      end else if (rcnt_q != 8'hFF) begin
        rcnt_d = rcnt_q + 8'd1;
      end
      trip = (rcnt_d == 8'(RCT_CUTOFF));
    end

    case (state_q)
      ST_FILL: begin
        if (emit) begin
          if (fcnt_q == FCW'(W - 1)) begin
            if (out_free) begin
              data_d  = acc_shift;
              valid_d = 1'b1;
              acc_d   = '0;
              fcnt_d  = '0;
            end else begin
              acc_d   = acc_shift;
              fcnt_d  = FCW'(W);
              state_d = ST_FULL;
            end
          end else begin
            acc_d  = acc_shift;
            fcnt_d = fcnt_q + FCW'(1);
          end
        end
      end
      ST_FULL: begin
        // emitted bits are dropped here; the parked word moves out as soon as the register frees
        if (out_free) begin
          data_d  = acc_q;
          valid_d = 1'b1;
          acc_d   = '0;
          fcnt_d  = '0;
          state_d = ST_FILL;
        end
      end
      default: begin
        valid_d = 1'b0;
      end
    endcase

    if (trip) begin
      state_d = ST_FAIL;
      valid_d = 1'b0;
      acc_d   = '0;
      fcnt_d  = '0;
      hf_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      phase_q <= 1'b0;
      first_q <= 1'b0;
      lastb_q <= 1'b0;
      rcnt_q  <= 8'd0;
      acc_q   <= '0;
      fcnt_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      hf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      first_q <= first_d;
      lastb_q <= lastb_d;
      rcnt_q  <= rcnt_d;
      acc_q   <= acc_d;
      fcnt_q  <= fcnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      hf_q    <= hf_d;
    end
  end

  assign out_if.valid  = valid_q;
  assign out_if.data   = data_q;
  assign health_fail_o = hf_q;

endmodule

// File: doc/trng_vn_packer.md
# trng_vn_packer

Post-processing stage directly downstream of the ring-oscillator TRNG. It samples the registered raw random bit once per clock and removes bias with a von Neumann corrector. It packs the debiased bits into W-bit words and hands them to the consumer over a valid/ready interface. A repetition-count health test on the raw stream latches a sticky failure flag and blocks all further output until reset.

## Interface
- W, default 32: output word width in bits (W ≥ 2).
- RCT_CUTOFF, default 32: raw-bit run length that trips the repetition-count test (2 ≤ RCT_CUTOFF ≤ 255).
- clk  in  1  system clock; the only clock.
- rst  in  1  reset: synchronous, active-high.
- raw_bit  in  1  raw random bit from the TRNG capture flop. Already synchronous to clk.
- en  in  1  sample enable. raw_bit is consumed only on cycles with en=1.
- ready  in  1  consumer ready.
- valid  out  1  data holds a word not yet transferred.
- data  out  W  packed debiased word.
- health_fail  out  1  sticky repetition-count failure.

## Operation
- Pair collector:
  - phase bit toggles on every sampled cycle (en=1).
  - phase=0: store raw_bit in first.
  - phase=1: compare raw_bit with first. 01 emits 0, 10 emits 1 (the emitted bit equals first). 00 and 11 emit nothing.
  - en=0: phase, first and all counters hold.
- Accumulator:
  - Shift register acc[W-1:0] with fill counter fcnt (0..W, width clog2(W+1)).
  - Each emitted bit shifts in at the LSB (acc <= {acc[W-2:0], bit}) and fcnt increments. The first emitted bit ends up at data[W-1].
- States:
  - FILL: accepting emitted bits.
  - FULL: fcnt=W, word waiting for the output register.
  - FAIL: health test tripped.
- FILL → completion: when the W-th bit is emitted, the word {acc[W-2:0], bit} goes straight into data, valid=1, fcnt=0, state stays FILL. This happens only if the output register is free, meaning valid=0, or valid&ready in the same cycle. Otherwise the completed word is kept in acc and the state moves to FULL.
- FULL: further emitted bits are discarded while the pair collector keeps running. On the first edge where the output register is free, acc moves to data, valid=1, fcnt=0, and the state returns to FILL.
- Output handshake:
  - Transfer occurs on an edge with valid&ready.
  - data is stable while valid=1 and ready=0.
  - valid clears after a transfer unless a new word loads on the same edge.
- Repetition-count test on raw samples:
  - rcnt (8 bits) with last bit lastb.
  - First sample after reset: rcnt=1.
  - Same value as lastb: rcnt+1, saturating at 255. Different value: rcnt=1.
  - When rcnt reaches RCT_CUTOFF: health_fail=1 and state=FAIL.
- FAIL:
  - valid=0 and acc/fcnt cleared. Any pending or held word is dropped, even if valid&ready on that same edge.
  - health_fail stays 1 and nothing is emitted until rst.
- Reset (any cycle, including mid-word or during a pending handshake), outputs and internal state:
  - valid=0, data=0, health_fail=0.
  - fcnt=0, acc=0, phase=0, rcnt=0, state=FILL.
  - Partial words are lost.

## Timing
- All state updates on rising clk. No combinational path from inputs to outputs.
- Pair completion: the second bit of a pair sampled at edge t is reflected in acc/fcnt at edge t.
- Word latency: valid rises at the edge that samples the final pair's second bit.
  - Minimum is 2W enabled cycles per word, with all pairs unequal.
  - Throughput is at most one word per 2W cycles.
- health_fail rises at the edge that samples the RCT_CUTOFF-th identical raw bit. valid is 0 after that same edge.
- Reset takes effect at the first edge with rst=1. The first sample is taken at the first edge with rst=0 and en=1.

## Test plan
- W=8, en=1, ready=1, raw pairs "10" ×8 → valid=1 with data=0xFF after the 16th sample edge, for one cycle. Repeat with pairs "01" ×8 → data=0x00.
- Ordering and discard: W=8, pairs 10,00,01,11,10,01,01,10,10,10 (20 samples; 00/11 discarded) → data=0xA7 (1,0,1,0,0,1,1,1 MSB first) at the 20th edge. With en toggled between samples, the same word results.
- Backpressure: W=8, ready=0, feed 32 samples of "10" → first word 0xFF held stable and valid=1. Second word sits in FULL and later bits are dropped. Raise ready → 0xFF transfers, then the held 0xFF loads on the same edge. Bit count resumes at 0.
- Health: RCT_CUTOFF=8, feed raw 1s → health_fail=1 at the 8th sampled edge and valid=0. Later alternating input keeps valid=0 and health_fail=1 until rst.
- Reset mid-operation: rst asserted after 7 emitted bits while valid=1, ready=0 → next cycle valid=0, data=0, health_fail=0. The next word needs 2W fresh enabled samples.
- Simultaneous events: word completes on the same edge as valid&ready of the previous word → new word in data, valid stays 1, no loss. Health trip on the same edge as word completion → no word, valid=0.
